usb_ep_buf: RTL

USB_EP_BUF -- requirements
Module: usb_ep_buf

---
 rtl/usb_pkg.sv | 17 +
 rtl/usb_pkt_ram.sv | 23 ++
 rtl/usb_ep_buf.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared handshake encodings and endpoint-buffer FSM states for the USB device core.
package usb_pkg;

    localparam logic [1:0] HS_ACK   = 2'b00;
    localparam logic [1:0] HS_NONE  = 2'b01;
    localparam logic [1:0] HS_NAK   = 2'b10;
    localparam logic [1:0] HS_STALL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_OUT_RX,
        ST_IN_TX,
        ST_FINISH
    } ep_state_t;

endpackage

// File: rtl/usb_pkt_ram.sv
// Single-packet payload store: one write port, one registered read port.
module usb_pkt_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/usb_ep_buf.sv
// Endpoint buffer manager: answers OUT/SETUP/IN transactions from the USB core,
// holds one OUT packet and one armed IN packet, tracks per-endpoint toggles and halts.
module usb_ep_buf
    import usb_pkg::*;
#(
    parameter  int unsigned NUM_EP  = 2,
    parameter  int unsigned MAX_PKT = 64,
    localparam int unsigned EPW     = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
    localparam int unsigned AW      = $clog2(MAX_PKT)
) (
    input  logic              clk48mhz,
    input  logic              rst,
    input  logic              usb_rst,
    input  logic [3:0]        endpoint,
    input  logic              transaction_active,
    input  logic              direction_in,
    input  logic              setup,
    input  logic              success,
    input  logic              data_strobe,
    input  logic [7:0]        data_out,
    output logic [7:0]        data_in,
    output logic              data_in_valid,
    output logic              data_toggle,
    output logic [1:0]        handshake,
    output logic              out_full,
    output logic [EPW-1:0]    out_ep,
    output logic              out_setup,
    output logic [AW:0]       out_len,
    input  logic [AW-1:0]     out_rd_addr,
    output logic [7:0]        out_rd_data,
    input  logic              out_release,
    input  logic              in_wr_en,
    input  logic [AW-1:0]     in_wr_addr,
    input  logic [7:0]        in_wr_data,
    input  logic              in_commit,
    input  logic [EPW-1:0]    in_commit_ep,
    input  logic [AW:0]       in_commit_len,
    output logic              in_busy,
    output logic              in_done,
    input  logic [NUM_EP-1:0] stall_set,
    input  logic [NUM_EP-1:0] stall_clr,
    output logic              out_err
);

    localparam logic [AW:0] PKT_MAX = (AW+1)'(MAX_PKT);

    ep_state_t r_state, w_state_nxt;

    logic              r_ta_q, r_ds_q;
    logic [EPW-1:0]    r_ep;
    logic              r_dir, r_setup, r_tog, r_ovf;
    logic [1:0]        r_hs;
    logic [AW:0]       r_idx;
    logic              r_out_full, r_out_setup, r_out_err;
    logic [EPW-1:0]    r_out_ep;
    logic [AW:0]       r_out_len;
    logic              r_in_busy, r_in_done;
    logic [EPW-1:0]    r_in_ep;
    logic [AW:0]       r_in_len;
    logic [NUM_EP-1:0] r_tog_in, r_tog_out, r_stall;

    logic              w_ta_rise, w_ds_rise, w_ep_valid, w_ack;
    logic [EPW-1:0]    w_ep_idx;
    logic [1:0]        w_hs;
    logic              w_tog;
    logic              w_out_we, w_in_we, w_in_adv, w_in_valid;
    logic [AW:0]       w_idx_nxt;
    logic [7:0]        w_in_rdata;

    assign w_ta_rise  = transaction_active & ~r_ta_q;
    assign w_ds_rise  = data_strobe & ~r_ds_q;
    assign w_ep_valid = {1'b0, endpoint} < 5'(NUM_EP);
    assign w_ep_idx   = endpoint[EPW-1:0];
    assign w_ack      = (r_hs == HS_ACK);

    assign w_out_we   = (r_state == ST_OUT_RX) && w_ack && w_ds_rise && (r_idx < PKT_MAX);
    assign w_in_we    = in_wr_en & ~r_in_busy;
    assign w_in_adv   = (r_state == ST_IN_TX) && w_ack && w_ds_rise && (r_idx < r_in_len);
    assign w_idx_nxt  = r_idx + {{AW{1'b0}}, w_in_adv};
    assign w_in_valid = (r_state == ST_IN_TX) && w_ack && (r_idx < r_in_len);

    // Response is decided from the live inputs on the rising edge so it is already valid in DECIDE.
    always_comb begin
        w_hs  = HS_NONE;
        w_tog = 1'b0;
        if (w_ep_valid) begin
            if (setup) begin
                w_hs = HS_ACK;
            end else if (!direction_in) begin
                if (r_stall[w_ep_idx])     w_hs = HS_STALL;
                else if (r_out_full)       w_hs = HS_NAK;
                else begin
                    w_hs  = HS_ACK;
                    w_tog = r_tog_out[w_ep_idx];
                end
            end else begin
                if (r_stall[w_ep_idx])     w_hs = HS_STALL;
                else if (!r_in_busy || (5'(r_in_ep) != {1'b0, endpoint})) w_hs = HS_NAK;
                else begin
                    w_hs  = HS_ACK;
                    w_tog = r_tog_in[w_ep_idx];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_ta_rise && w_ep_valid) w_state_nxt = ST_DECIDE;
            ST_DECIDE: w_state_nxt = r_dir ? ST_IN_TX : ST_OUT_RX;
            ST_OUT_RX,
            ST_IN_TX:  if (!transaction_active) w_state_nxt = ST_FINISH;
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk48mhz or posedge rst) begin
        if (rst)          r_state <= ST_IDLE;
        else if (usb_rst) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_ff @(posedge clk48mhz or posedge rst) begin
        if (rst) begin
            // Seeded high so a transaction still active across reset release is not mistaken for a new one.
            r_ta_q      <= 1'b1;
            r_ds_q      <= 1'b0;
            r_ep        <= '0;
            r_dir       <= 1'b0;
            r_setup     <= 1'b0;
            r_hs        <= HS_NONE;
            r_tog       <= 1'b0;
            r_ovf       <= 1'b0;
            r_idx       <= '0;
            r_out_full  <= 1'b0;
            r_out_ep    <= '0;
            r_out_setup <= 1'b0;
            r_out_len   <= '0;
            r_out_err   <= 1'b0;
            r_in_busy   <= 1'b0;
            r_in_done   <= 1'b0;
            r_in_ep     <= '0;
            r_in_len    <= '0;
            r_tog_in    <= '0;
            r_tog_out   <= '0;
            r_stall     <= '0;
        end else begin
            r_ta_q    <= transaction_active;
            r_ds_q    <= data_strobe;
            r_in_done <= 1'b0;
            r_out_err <= 1'b0;
            if (usb_rst) begin
                r_ta_q     <= 1'b1;
                r_hs       <= HS_NONE;
                r_tog      <= 1'b0;
                r_out_full <= 1'b0;
                r_in_busy  <= 1'b0;
                r_tog_in   <= '0;
                r_tog_out  <= '0;
                r_stall    <= '0;
            end else begin
                if (out_release) r_out_full <= 1'b0;
                if (in_commit && !r_in_busy) begin
                    r_in_busy <= 1'b1;
                    r_in_ep   <= in_commit_ep;
                    r_in_len  <= (in_commit_len > PKT_MAX) ? PKT_MAX : in_commit_len;
                end
                case (r_state)
                    ST_IDLE: if (w_ta_rise && w_ep_valid) begin
                        r_ep    <= w_ep_idx;
                        r_dir   <= direction_in & ~setup;
                        r_setup <= setup;
                        r_hs    <= w_hs;
                        r_tog   <= w_tog;
                        r_idx   <= '0;
                        r_ovf   <= 1'b0;
                    end
                    ST_OUT_RX: if (w_ack && w_ds_rise) begin
                        if (r_idx < PKT_MAX) r_idx <= r_idx + (AW+1)'(1);
                        else                 r_ovf <= 1'b1;
                    end
                    ST_IN_TX: r_idx <= w_idx_nxt;
                    ST_FINISH: begin
                        r_hs  <= HS_NONE;
                        r_tog <= 1'b0;
                        if (w_ack && !r_dir) begin
                            if (r_ovf) begin
                                r_out_err  <= 1'b1;
                                r_out_full <= 1'b0;
                            end else if (success) begin
                                r_out_full  <= 1'b1;
                                r_out_ep    <= r_ep;
                                r_out_setup <= r_setup;
                                r_out_len   <= r_idx;
                                if (r_setup) begin
                                    r_stall[r_ep]   <= 1'b0;
                                    r_tog_in[r_ep]  <= 1'b1;
                                    r_tog_out[r_ep] <= 1'b1;
                                end else begin
                                    r_tog_out[r_ep] <= ~r_tog_out[r_ep];
                                end
                            end else if (r_setup) begin
                                // A failed SETUP has already overwritten the held packet.
                                r_out_full <= 1'b0;
                            end
                        end
                        if (w_ack && r_dir && success) begin
                            r_in_busy      <= 1'b0;
                            r_in_done      <= 1'b1;
                            r_tog_in[r_ep] <= ~r_tog_in[r_ep];
                        end
                    end
                    default: ;
                endcase
                for (int unsigned i = 0; i < NUM_EP; i++) begin
                    if (stall_clr[i]) begin
                        r_stall[i]   <= 1'b0;
                        r_tog_in[i]  <= 1'b0;
                        r_tog_out[i] <= 1'b0;
                    end
                    if (stall_set[i]) r_stall[i] <= 1'b1;
                end
            end
        end
    end

    usb_pkt_ram #(.DEPTH(MAX_PKT), .AW(AW)) u_out_ram (
        .i_clk   (clk48mhz),
        .i_we    (w_out_we),
        .i_waddr (r_idx[AW-1:0]),
        .i_wdata (data_out),
        .i_raddr (out_rd_addr),
        .o_rdata (out_rd_data)
    );

    // Read address looks one strobe ahead so data_in tracks the index with no extra cycle.
    usb_pkt_ram #(.DEPTH(MAX_PKT), .AW(AW)) u_in_ram (
        .i_clk   (clk48mhz),
        .i_we    (w_in_we),
        .i_waddr (in_wr_addr),
        .i_wdata (in_wr_data),
        .i_raddr (w_idx_nxt[AW-1:0]),
        .o_rdata (w_in_rdata)
    );

    assign handshake     = r_hs;
    assign data_toggle   = r_tog;
    assign data_in_valid = w_in_valid;
    assign data_in       = w_in_valid ? w_in_rdata : '0;
    assign out_full      = r_out_full;
    assign out_ep        = r_out_ep;
    assign out_setup     = r_out_setup;
    assign out_len       = r_out_len;
    assign in_busy       = r_in_busy;
    assign in_done       = r_in_done;
    assign out_err       = r_out_err;

endmodule
